// File: rtl/ternary_neuron_pkg.sv
// Shared encodings for the ternary neuron accumulator: result trits and FSM states.
package ternary_neuron_pkg;

  localparam logic [1:0] TRIT_POS  = 2'b01;
  localparam logic [1:0] TRIT_NEG  = 2'b11;
  localparam logic [1:0] TRIT_ZERO = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/ternary_neuron_acc_sat_add.sv
// Signed saturating adder: adds at W+1 bits and clamps the result back into W bits.
module sat_add_s #(
  parameter int W = 8
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] sum_o,
  output logic                sat_o
);

  logic signed [W:0] full;

  assign full = {a_i[W-1], a_i} + {b_i[W-1], b_i};

  // The top two bits disagree only when the true sum falls outside the W-bit range.
  always_comb begin
    sum_o = full[W-1:0];
    sat_o = 1'b0;
    if (full[W] != full[W-1]) begin
      sat_o = 1'b1;
      sum_o = full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/ternary_neuron_acc.sv
// Ternary neuron accumulator: sums (pos_cnt - neg_cnt) over up to MAX_CHUNKS chunk beats
// with saturation, then classifies the total against thresholds captured on the first beat.
module ternary_neuron_acc
  import ternary_neuron_pkg::*;
#(
  parameter int ACC_W      = 8,
  parameter int MAX_CHUNKS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              pos_cnt,
  input  logic [3:0]              neg_cnt,
  input  logic                    in_last,
  input  logic signed [ACC_W-1:0] thr_hi,
  input  logic signed [ACC_W-1:0] thr_lo,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_trit,
  output logic signed [ACC_W-1:0] out_sum,
  output logic                    out_sat,
  output logic                    out_ovf
);

  localparam int CNT_W = $clog2(MAX_CHUNKS + 1);

  // Handshake: a beat transfers on any cycle with in_valid & in_ready, a result on
  // out_valid & out_ready; in_ready depends only on registered state, never on out_ready.
  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] thr_hi_q, thr_hi_d;
  logic signed [ACC_W-1:0] thr_lo_q, thr_lo_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sat_q, sat_d;
  logic [1:0]              trit_q, trit_d;
  logic signed [ACC_W-1:0] sum_q, sum_d;
  logic                    osat_q, osat_d;
  logic                    ovf_q, ovf_d;

  logic                    beat;
  logic                    first_beat;
  logic signed [4:0]       diff;
  logic signed [ACC_W-1:0] diff_ext;
  logic signed [ACC_W-1:0] add_a;
  logic signed [ACC_W-1:0] add_sum;
  logic                    add_sat;
  logic signed [ACC_W-1:0] thr_hi_use;
  logic signed [ACC_W-1:0] thr_lo_use;
  logic [CNT_W-1:0]        cnt_next;
  logic                    max_hit;
  logic                    sat_new;
  logic [1:0]              trit_new;

  assign first_beat = (state_q == ST_IDLE);
  assign beat       = in_valid & in_ready;

  assign diff     = $signed({1'b0, pos_cnt}) - $signed({1'b0, neg_cnt});
  assign diff_ext = {{(ACC_W-5){diff[4]}}, diff};

  // The first beat starts from zero and from the live thresholds it is about to capture.
  assign add_a      = first_beat ? '0 : acc_q;
  assign thr_hi_use = first_beat ? thr_hi : thr_hi_q;
  assign thr_lo_use = first_beat ? thr_lo : thr_lo_q;
  assign cnt_next   = first_beat ? CNT_W'(1) : cnt_q + CNT_W'(1);
  assign max_hit    = (cnt_next == CNT_W'(MAX_CHUNKS));
  assign sat_new    = add_sat | (!first_beat & sat_q);

  sat_add_s #(.W(ACC_W)) u_sat_add (
    .a_i   (add_a),
    .b_i   (diff_ext),
    .sum_o (add_sum),
    .sat_o (add_sat)
  );

  // Upper threshold wins when the thresholds are inverted.
  always_comb begin
    trit_new = TRIT_ZERO;
    if (add_sum > thr_hi_use) begin
      trit_new = TRIT_POS;
    end else if (add_sum < thr_lo_use) begin
      trit_new = TRIT_NEG;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    thr_hi_d  = thr_hi_q;
    thr_lo_d  = thr_lo_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    trit_d    = trit_q;
    sum_d     = sum_q;
    osat_d    = osat_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (beat) begin
          acc_d = add_sum;
          cnt_d = cnt_next;
          sat_d = sat_new;
          if (first_beat) begin
            thr_hi_d = thr_hi;
            thr_lo_d = thr_lo;
          end
          state_d = ST_ACCUM;
          if (in_last || max_hit) begin
            state_d = ST_DONE;
            sum_d   = add_sum;
            trit_d  = trit_new;
            osat_d  = sat_new;
            ovf_d   = !in_last;
          end
        end
      end
      ST_DONE: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      thr_hi_q <= '0;
      thr_lo_q <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      trit_q   <= TRIT_ZERO;
      sum_q    <= '0;
      osat_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      thr_hi_q <= thr_hi_d;
      thr_lo_q <= thr_lo_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      trit_q   <= trit_d;
      sum_q    <= sum_d;
      osat_q   <= osat_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_trit = trit_q;
  assign out_sum  = sum_q;
  assign out_sat  = osat_q;
  assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_ternary_neuron_acc.sv
// Directed bench for ternary_neuron_acc: an 8-bit instance for most scenarios and a 6-bit
// instance for saturation corners.
module tb_ternary_neuron_acc;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_last, out_ready;
  logic [3:0]        pos_cnt, neg_cnt;
  logic signed [7:0] thr_hi, thr_lo;
  logic              in_ready, out_valid, out_sat, out_ovf;
  logic [1:0]        out_trit;
  logic signed [7:0] out_sum;

  logic              v6, l6, or6;
  logic [3:0]        p6, n6;
  logic signed [5:0] th6, tl6;
  logic              rdy6, ov6, sat6, ovf6;
  logic [1:0]        trit6;
  logic signed [5:0] sum6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ternary_neuron_acc #(.ACC_W(8), .MAX_CHUNKS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pos_cnt(pos_cnt), .neg_cnt(neg_cnt), .in_last(in_last),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .out_valid(out_valid), .out_ready(out_ready),
    .out_trit(out_trit), .out_sum(out_sum), .out_sat(out_sat), .out_ovf(out_ovf)
  );

  ternary_neuron_acc #(.ACC_W(6), .MAX_CHUNKS(4)) dut6 (
    .clk(clk), .rst(rst), .in_valid(v6), .in_ready(rdy6),
    .pos_cnt(p6), .neg_cnt(n6), .in_last(l6),
    .thr_hi(th6), .thr_lo(tl6), .out_valid(ov6), .out_ready(or6),
    .out_trit(trit6), .out_sum(sum6), .out_sat(sat6), .out_ovf(ovf6)
  );

  task automatic send(input logic [3:0] p, input logic [3:0] n, input logic last);
    in_valid = 1'b1; pos_cnt = p; neg_cnt = n; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send6(input logic [3:0] p, input logic [3:0] n, input logic last);
    v6 = 1'b1; p6 = p; n6 = n; l6 = last;
    @(posedge clk); #1;
    v6 = 1'b0; l6 = 1'b0;
  endtask

  task automatic drain;
    out_ready = 1'b1; or6 = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; or6 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", in_ready); end
    checks++; if (out_sum !== 8'sd0) begin errors++; $display("FAIL reset_sum got %0d want 0", out_sum); end
    checks++; if (out_trit !== 2'b00) begin errors++; $display("FAIL reset_trit got %b want 00", out_trit); end
    checks++; if ({out_sat, out_ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {out_sat, out_ovf}); end
    checks++; if ({ov6, rdy6} !== 2'b01) begin errors++; $display("FAIL reset6_vr got %b want 01", {ov6, rdy6}); end
  endtask

  task automatic test_single;
    thr_hi = 8'sd3; thr_lo = -8'sd3;
    send(4'd7, 4'd2, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", out_valid); end
    checks++; if (out_sum !== 8'sd5) begin errors++; $display("FAIL single_sum got %0d want 5", out_sum); end
    checks++; if (out_trit !== 2'b01) begin errors++; $display("FAIL single_trit got %b want 01", out_trit); end
    checks++; if ({out_sat, out_ovf} !== 2'b00) begin errors++; $display("FAIL single_flags got %b want 00", {out_sat, out_ovf}); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL single_ready_done got %0b want 0", in_ready); end
    drain();
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL single_release got %b want 01", {out_valid, in_ready}); end
  endtask

  task automatic test_three_chunks;
    thr_hi = 8'sd0; thr_lo = -8'sd4;
    send(4'd2, 4'd6, 1'b0);
    send(4'd1, 4'd5, 1'b0);
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL three_mid got %b want 01", {out_valid, in_ready}); end
    send(4'd0, 4'd3, 1'b1);
    checks++; if (out_sum !== -8'sd11) begin errors++; $display("FAIL three_sum got %0d want -11", out_sum); end
    checks++; if (out_trit !== 2'b11) begin errors++; $display("FAIL three_trit got %b want 11", out_trit); end
    checks++; if ({out_sat, out_ovf} !== 2'b00) begin errors++; $display("FAIL three_flags got %b want 00", {out_sat, out_ovf}); end
    drain();
  endtask

  task automatic test_saturation;
    th6 = 6'sd0; tl6 = 6'sd0;
    for (int i = 0; i < 4; i++) send6(4'd15, 4'd0, i == 3);
    checks++; if (ov6 !== 1'b1) begin errors++; $display("FAIL satp_valid got %0b want 1", ov6); end
    checks++; if (sum6 !== 6'sd31) begin errors++; $display("FAIL satp_sum got %0d want 31", sum6); end
    checks++; if ({sat6, ovf6, trit6} !== 4'b1001) begin errors++; $display("FAIL satp_flags got %b want 1001", {sat6, ovf6, trit6}); end
    drain();
    th6 = 6'sd5; tl6 = -6'sd5;
    for (int i = 0; i < 3; i++) send6(4'd0, 4'd15, i == 2);
    checks++; if (sum6 !== -6'sd32) begin errors++; $display("FAIL satn_sum got %0d want -32", sum6); end
    checks++; if ({sat6, ovf6, trit6} !== 4'b1011) begin errors++; $display("FAIL satn_flags got %b want 1011", {sat6, ovf6, trit6}); end
    drain();
    send6(4'd1, 4'd0, 1'b1);
    checks++; if ({sum6, sat6} !== {6'sd1, 1'b0}) begin errors++; $display("FAIL sat_clear got sum %0d sat %0b want sum 1 sat 0", sum6, sat6); end
    drain();
  endtask

  task automatic test_overflow;
    thr_hi = 8'sd0; thr_lo = 8'sd0;
    for (int i = 0; i < 4; i++) send(4'd1, 4'd0, 1'b0);
    checks++; if ({out_valid, in_ready, out_ovf} !== 3'b101) begin errors++; $display("FAIL ovf_done got %b want 101", {out_valid, in_ready, out_ovf}); end
    checks++; if (out_sum !== 8'sd4) begin errors++; $display("FAIL ovf_sum got %0d want 4", out_sum); end
    in_valid = 1'b1; pos_cnt = 4'd2; neg_cnt = 4'd0; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, out_ovf, out_trit, out_sum} !== {3'b101, 2'b01, 8'sd4}) begin
        errors++;
        $display("FAIL ovf_hold%0d got v%0b r%0b o%0b t%b s%0d want v1 r0 o1 t01 s4", i, out_valid, in_ready, out_ovf, out_trit, out_sum);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL ovf_release got %b want 01", {out_valid, in_ready}); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if ({out_valid, out_ovf} !== 2'b10) begin errors++; $display("FAIL ovf_held_beat got %b want 10", {out_valid, out_ovf}); end
    checks++; if (out_sum !== 8'sd2) begin errors++; $display("FAIL ovf_held_sum got %0d want 2", out_sum); end
    drain();
    for (int i = 0; i < 4; i++) send(4'd1, 4'd0, i == 3);
    checks++; if ({out_valid, out_ovf} !== 2'b10) begin errors++; $display("FAIL last_at_max got %b want 10", {out_valid, out_ovf}); end
    drain();
  endtask

  task automatic test_thr_capture;
    thr_hi = 8'sd10; thr_lo = -8'sd10;
    send(4'd3, 4'd1, 1'b0);
    thr_hi = -8'sd10;
    send(4'd3, 4'd1, 1'b1);
    checks++; if (out_sum !== 8'sd4) begin errors++; $display("FAIL thr_sum got %0d want 4", out_sum); end
    checks++; if (out_trit !== 2'b00) begin errors++; $display("FAIL thr_trit got %b want 00", out_trit); end
    drain();
  endtask

  task automatic test_idle_gap;
    thr_hi = 8'sd0; thr_lo = 8'sd0;
    send(4'd4, 4'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL gap_wait got %b want 01", {out_valid, in_ready}); end
    send(4'd0, 4'd1, 1'b1);
    checks++; if ({out_sum, out_trit} !== {8'sd3, 2'b01}) begin errors++; $display("FAIL gap_result got sum %0d trit %b want sum 3 trit 01", out_sum, out_trit); end
    drain();
  endtask

  task automatic test_back_to_back;
    int n_valid;
    n_valid = 0;
    thr_hi = 8'sd0; thr_lo = 8'sd0;
    out_ready = 1'b1;
    in_valid = 1'b1; pos_cnt = 4'd2; neg_cnt = 4'd0; in_last = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) n_valid++;
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    checks++; if (n_valid !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", n_valid); end
    checks++; if ({out_valid, out_sum} !== {1'b0, 8'sd2}) begin errors++; $display("FAIL b2b_end got v%0b s%0d want v0 s2", out_valid, out_sum); end
  endtask

  task automatic test_reset_mid;
    thr_hi = 8'sd0; thr_lo = 8'sd0;
    send(4'd5, 4'd0, 1'b0);
    send(4'd5, 4'd0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if ({out_valid, in_ready, out_sum} !== {2'b01, 8'sd0}) begin errors++; $display("FAIL rstmid got v%0b r%0b s%0d want v0 r1 s0", out_valid, in_ready, out_sum); end
    send(4'd3, 4'd3, 1'b1);
    checks++; if ({out_valid, out_sum, out_trit} !== {1'b1, 8'sd0, 2'b00}) begin errors++; $display("FAIL rstmid_fresh got v%0b s%0d t%b want v1 s0 t00", out_valid, out_sum, out_trit); end
    checks++; if ({out_sat, out_ovf} !== 2'b00) begin errors++; $display("FAIL rstmid_flags got %b want 00", {out_sat, out_ovf}); end
    send(4'd1, 4'd0, 1'b1);
    rst = 1'b1; in_valid = 1'b1; pos_cnt = 4'd7; in_last = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    checks++; if ({out_valid, in_ready, out_sum} !== {2'b01, 8'sd0}) begin errors++; $display("FAIL rstdone got v%0b r%0b s%0d want v0 r1 s0", out_valid, in_ready, out_sum); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    pos_cnt = 4'd0; neg_cnt = 4'd0; thr_hi = 8'sd0; thr_lo = 8'sd0;
    v6 = 1'b0; l6 = 1'b0; or6 = 1'b0; p6 = 4'd0; n6 = 4'd0; th6 = 6'sd0; tl6 = 6'sd0;
    test_reset();
    test_single();
    test_three_chunks();
    test_saturation();
    test_overflow();
    test_thr_capture();
    test_idle_gap();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ternary_neuron_acc.md
TERNARY_NEURON_ACC -- requirements
Module: ternary_neuron_acc

Interface
REQ-001 Parameter ACC_W, default 8, signed accumulator width (>=6).
REQ-002 Parameter MAX_CHUNKS, default 4, maximum 10-input chunks per neuron evaluation (>=1).
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Port in_valid  input  1  chunk beat valid.
REQ-006 Port in_ready  output  1  block accepts a chunk beat this cycle.
REQ-007 Port pos_cnt  input  4  unsigned popcount of the +1-weighted inputs of the chunk (0..15 legal; approximate counters may exceed 10).
REQ-008 Port neg_cnt  input  4  unsigned popcount of the -1-weighted inputs of the chunk (0..15).
REQ-009 Port in_last  input  1  final chunk of the current evaluation.
REQ-010 Port thr_hi  input  ACC_W  signed upper threshold.
REQ-011 Port thr_lo  input  ACC_W  signed lower threshold.
REQ-012 Port out_valid  output  1  result valid.
REQ-013 Port out_ready  input  1  consumer accepts result.
REQ-014 Port out_trit  output  2  ternary result: 2'b01 = +1, 2'b11 = -1, 2'b00 = 0; 2'b10 never driven.
REQ-015 Port out_sum  output  ACC_W  signed final accumulated sum.
REQ-016 Port out_sat  output  1  saturation occurred during this evaluation.
REQ-017 Port out_ovf  output  1  evaluation force-terminated at MAX_CHUNKS without in_last.

Function
REQ-018 FSM states IDLE, ACCUM, DONE; beat = in_valid & in_ready.
REQ-019 in_ready = 1 in IDLE and ACCUM, 0 in DONE (no combinational path from out_ready).
REQ-020 IDLE beat: acc <= sat(0 + pos_cnt - neg_cnt), thr_hi/thr_lo captured into registers, chunk_cnt <= 1, sat flag cleared then set if saturated; next state ACCUM, or DONE if in_last or MAX_CHUNKS == 1.
REQ-021 ACCUM beat: acc <= sat(acc + pos_cnt - neg_cnt), chunk_cnt increments; to DONE when in_last or chunk_cnt+1 == MAX_CHUNKS.
REQ-022 Termination by count without in_last sets out_ovf = 1; in_last on the MAX_CHUNKS-th beat sets out_ovf = 0.
REQ-023 Difference pos_cnt - neg_cnt computed at 5-bit signed, sign-extended to ACC_W+1 before addition; result clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; any clamp sets sat flag sticky for the evaluation.
REQ-024 Thresholds sampled only on the first beat; later changes ignored until next evaluation.
REQ-025 Classification from final acc and captured thresholds: acc > thr_hi -> +1; else acc < thr_lo -> -1; else 0 (if thr_lo > thr_hi, +1 test has priority).
REQ-026 out_valid = 1 exactly in DONE; out_trit/out_sum/out_sat/out_ovf registered, stable while out_valid & !out_ready.
REQ-027 Latency: out_valid asserts the cycle after the terminating beat is accepted.
REQ-028 DONE & out_ready: next state IDLE; back-to-back throughput is one evaluation per (chunks + 1) cycles.
REQ-029 No beat accepted in DONE; in_valid held by upstream is accepted the first IDLE cycle.
REQ-030 Idle cycles (in_valid = 0) in ACCUM leave all state unchanged.

Reset
REQ-031 rst dominates all inputs, including mid-evaluation and during DONE; partial evaluation discarded.
REQ-032 Reset values: state IDLE, acc 0, chunk_cnt 0, out_valid 0, out_trit 2'b00, out_sum 0, out_sat 0, out_ovf 0; in_ready 1 the first cycle after rst deasserts.

Structure
REQ-033 Package ternary_neuron_pkg holds trit encoding constants (TRIT_POS, TRIT_NEG, TRIT_ZERO) and the FSM state enum type.
REQ-034 One sub-module sat_add_s (parameterised signed saturating adder returning sum and saturate flag) instantiated once.
REQ-035 Implementation size 120-400 lines RTL, no latches, no multi-cycle paths.

Verification
REQ-036 Single chunk pos=7, neg=2, in_last=1, thr_hi=3, thr_lo=-3 -> next cycle out_valid=1, out_sum=5, out_trit=01, sat=0, ovf=0.
REQ-037 Three chunks (2,6),(1,5),(0,3) last on third, thr_hi=0, thr_lo=-4 -> out_sum=-11, out_trit=11.
REQ-038 ACC_W=6, four chunks (15,0) with last on fourth -> out_sum=31, out_sat=1, out_trit=01.
REQ-039 MAX_CHUNKS=4, five beats without in_last -> fifth beat stalled (in_ready=0 after fourth), out_ovf=1; out_ready low 3 cycles -> outputs stable, in_ready=0 throughout.
REQ-040 rst asserted after second of three chunks -> next cycle out_valid=0, acc 0; fresh single chunk (3,3), thr_hi=0, thr_lo=0 -> out_sum=0, out_trit=00.
REQ-041 thr_hi changed from 10 to -10 after first beat of a two-chunk vector summing to 4 -> out_trit=00 with thr_lo=-10 (captured thresholds used).
